// File: rtl/mask_scanner.sv
// Raster-scans a 1-bpp mask frame buffer and streams (x, y) for every set pixel,
// followed by a single end-of-frame tabulate pulse for the centroid stage.
module mask_scanner #(
   parameter int H_PIXELS     = 1280,
   parameter int V_PIXELS     = 720,
   parameter int ADDR_WIDTH   = 20,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  start_in,
   output logic [ADDR_WIDTH-1:0] mask_addr_out,
   input  logic                  mask_data_in,
   output logic [10:0]           x_out,
   output logic [9:0]            y_out,
   output logic                  valid_out,
   output logic                  tabulate_out,
   output logic                  busy_out,
   output logic [ADDR_WIDTH-1:0] pixel_count_out
);

   localparam int X_W = 11;
   localparam int Y_W = 10;

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, TAB} state_t;

   typedef struct packed {
      logic           issued;
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
   } tag_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] run_q, run_d;
   logic [ADDR_WIDTH-1:0] count_q, count_d;
   logic [X_W-1:0]        x_q, x_d;
   logic [Y_W-1:0]        y_q, y_d;
   logic [2:0]            drain_q, drain_d;
   logic [X_W-1:0]        x_out_q;
   logic [Y_W-1:0]        y_out_q;
   logic                  valid_q;
   logic                  hit;
   logic                  last_pixel;
   tag_t                  pipe_q [READ_LATENCY];

   // The tail of the tag pipeline lines up with the BRAM data for the same address.
   assign hit        = pipe_q[READ_LATENCY-1].issued & mask_data_in;
   assign last_pixel = (x_q == X_W'(H_PIXELS - 1)) && (y_q == Y_W'(V_PIXELS - 1));

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
      state_d = state_q;
      addr_d  = addr_q;
      x_d     = x_q;
      y_d     = y_q;
      drain_d = drain_q;
      run_d   = hit ? run_q + 1'b1 : run_q;
      count_d = count_q;

      unique case (state_q)
         IDLE: begin
            if (start_in) begin
               state_d = SCAN;
               addr_d  = '0;
               x_d     = '0;
               y_d     = '0;
               run_d   = '0;
            end
         end
         SCAN: begin
            if (last_pixel) begin
               state_d = DRAIN;
               drain_d = '0;
            end else begin
               addr_d = addr_q + 1'b1;
               if (x_q == X_W'(H_PIXELS - 1)) begin
                  x_d = '0;
                  y_d = y_q + 1'b1;
               end else begin
                  x_d = x_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            // The final hit has already been counted by the last drain cycle.
            if (drain_q == 3'(READ_LATENCY)) begin
               state_d = TAB;
               count_d = run_q;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         TAB: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= IDLE;
         addr_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         drain_q <= '0;
         run_q   <= '0;
         count_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state_q <= state_d;
         addr_q  <= addr_d;
         x_q     <= x_d;
         y_q     <= y_d;
         drain_q <= drain_d;
         run_q   <= run_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         // NOTE: the tag pipeline is a short register chain, not a RAM, so it is safe to clear on reset.
         for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
         valid_q <= 1'b0;
         x_out_q <= '0;
         y_out_q <= '0;
      end else begin
         pipe_q[0] <= '{issued: (state_q == SCAN), x: x_q, y: y_q};
         for (int i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
         valid_q <= hit;
         if (hit) begin
            x_out_q <= pipe_q[READ_LATENCY-1].x;
            y_out_q <= pipe_q[READ_LATENCY-1].y;
         end
      end
   end

   assign mask_addr_out   = addr_q;
   assign x_out           = x_out_q;
   assign y_out           = y_out_q;
   assign valid_out       = valid_q;
   assign tabulate_out    = (state_q == TAB);
   assign busy_out        = (state_q != IDLE);
   assign pixel_count_out = count_q;

endmodule
